load_store_unit: RTL
====================

Name: load_store_unit

Overview:
Memory-stage responder for the decoder's DATA_MEM_READ / DATA_MEM_WRITE encodings. It turns a decoded load/store into a word-aligned, byte-enabled request on the data-memory bus and stalls the pipeline until the bus acknowledges. On loads it returns a sign- or zero-extended result to writeback. It sits between the EX/MEM pipeline register and the data cache or memory.

Parameters:
TIMEOUT_CYCLES, 255, number of WAIT cycles without MEM_ACK before the request is aborted (1..255).
ADDR_WIDTH, 32, width of the byte address from the ALU.

Ports:
CLK  input  1  system clock
RESET  input  1  asynchronous, active-high reset
DATA_MEM_READ  input  4  [3] = load enable; [2:0] = funct3 (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU)
DATA_MEM_WRITE  input  3  [2] = store enable; [1:0] = width (00 byte, 01 half, 10 word)
ADDRESS  input  ADDR_WIDTH  byte address (ALU result)
WRITE_DATA  input  32  rs2 value for stores
READ_DATA  output  32  extended load result; registered
BUSY  output  1  pipeline stall request
BUS_ERROR  output  1  one-cycle pulse on timeout
MEM_READ  output  1  bus read strobe
MEM_WRITE  output  1  bus write strobe
MEM_ADDRESS  output  ADDR_WIDTH-2  word address = ADDRESS[ADDR_WIDTH-1:2]
MEM_WRITEDATA  output  32  byte-lane-shifted store data
MEM_BYTE_EN  output  4  active byte lanes
MEM_READDATA  input  32  raw bus word
MEM_ACK  input  1  bus completion, valid for one cycle

Behaviour:
- Reset values: all outputs 0; state IDLE; timeout counter 0. Reset asserted mid-operation drops the strobes immediately (asynchronously) and discards the transaction.
- States: IDLE, WAIT, DONE.
- IDLE:
  - A request is present when DATA_MEM_WRITE[2] or DATA_MEM_READ[3] is set.
  - BUSY = request, combinationally in the same cycle.
  - On the next edge: latch address, byte enables, shifted data, funct3 and byte offset; raise MEM_READ or MEM_WRITE; go to WAIT.
  - If both enables are set, the store wins and the load is ignored.
- WAIT:
  - BUSY = 1; strobes and MEM_* outputs are held stable; the counter increments each cycle.
  - MEM_ACK = 1: drop the strobes; on a read, capture the extended READ_DATA; go to DONE.
  - Counter reaches TIMEOUT_CYCLES with no ack: drop the strobes, pulse BUS_ERROR, set READ_DATA to 0, go to DONE.
  - MEM_ACK arriving in the same cycle as the timeout: the ack wins.
- DONE:
  - BUSY = 0 for exactly one cycle so the pipeline advances; the same instruction is not reissued. Then go to IDLE.
  - A new request can be accepted at the earliest in the cycle after DONE.
  - Minimum load/store latency: 3 cycles (accept, WAIT with ack, DONE).
- Byte enables:
  - Byte access: MEM_BYTE_EN = 0001 shifted left by ADDRESS[1:0].
  - Half access: 0011 shifted left by {ADDRESS[1],0}.
  - Word access: 1111.
- Store data: WRITE_DATA replicated across lanes (byte: 4 copies; half: 2 copies; word: as is).
- Load extract: select the lane from the latched offset. funct3[2] = 0 sign-extends; funct3[2] = 1 zero-extends.
- Reserved load funct3 (011, 110, 111): treated as LW.
- READ_DATA holds its value until the next completed load. Stores leave it unchanged.
- Misalignment (half with ADDRESS[0] = 1; word with ADDRESS[1:0] != 0): handled as defined under Optional Feature.

Optional Feature:
MISALIGN_TRAP_EN
- Defined:
  - A misaligned request issues no bus access.
  - Adds output MISALIGNED (1 bit), pulsed for one cycle.
  - The FSM goes IDLE -> DONE directly, BUSY is high for one cycle, and READ_DATA is unchanged.
- Undefined:
  - The low address bits are forced to the natural alignment (half: [0] = 0; word: [1:0] = 0).
  - The access then proceeds normally.

Decomposition:
- Shared package: state encoding (IDLE/WAIT/DONE), load funct3 constants (LB, LH, LW, LBU, LHU), store width constants, and opcode constants shared with the control unit.
- One natural sub-module, lsu_lane_align: combinational byte-enable generation, store data replication and load extract/extend. The FSM and counter stay in the top level.

Test Plan:
- SW at 0x00000010, data 0xDEADBEEF, ack on the second WAIT cycle -> MEM_ADDRESS = 0x4, BYTE_EN = 1111, WRITEDATA = 0xDEADBEEF; BUSY high 3 cycles; then DONE with BUSY = 0 for one cycle.
- LB at 0x...03, MEM_READDATA = 0x80AA55CC -> READ_DATA = 0xFFFFFF80. Repeat as LBU -> READ_DATA = 0x00000080.
- SH at 0x...02, WRITE_DATA = 0x00001234 -> BYTE_EN = 1100, WRITEDATA = 0x12341234. LH from the same lane with READDATA = 0x8001xxxx -> READ_DATA = 0xFFFF8001.
- TIMEOUT_CYCLES = 4, no ack on an LW -> BUS_ERROR pulses once after 4 WAIT cycles; READ_DATA = 0; back to IDLE.
- RESET asserted during WAIT -> MEM_READ falls without waiting for a clock edge; after release the unit is in IDLE with READ_DATA = 0; a later ack is ignored.
- Misaligned LW at 0x...06 -> with MISALIGN_TRAP_EN: MISALIGNED pulse and no strobe; without it: MEM_ADDRESS = 0x...1 (byte address 0x...04) and a normal word read.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// ============================================================================
// Module : load_store_unit_pkg
// Brief  : Shared encodings for the load/store unit and the control unit.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package load_store_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } access_size_e;

  // Load funct3 encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store width encodings
  localparam logic [1:0] SW_BYTE = 2'b00;
  localparam logic [1:0] SW_HALF = 2'b01;
  localparam logic [1:0] SW_WORD = 2'b10;

  // DATA_MEM_READ / DATA_MEM_WRITE opcodes as driven by the control unit
  localparam logic [3:0] MEM_RD_NONE = 4'b0000;
  localparam logic [3:0] MEM_RD_LB   = {1'b1, F3_LB};
  localparam logic [3:0] MEM_RD_LH   = {1'b1, F3_LH};
  localparam logic [3:0] MEM_RD_LW   = {1'b1, F3_LW};
  localparam logic [3:0] MEM_RD_LBU  = {1'b1, F3_LBU};
  localparam logic [3:0] MEM_RD_LHU  = {1'b1, F3_LHU};
  localparam logic [2:0] MEM_WR_NONE = 3'b000;
  localparam logic [2:0] MEM_WR_SB   = {1'b1, SW_BYTE};
  localparam logic [2:0] MEM_WR_SH   = {1'b1, SW_HALF};
  localparam logic [2:0] MEM_WR_SW   = {1'b1, SW_WORD};

  // Reserved load encodings fall through to a full word
  function automatic access_size_e load_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return SZ_BYTE;
      2'b01:   return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

  function automatic access_size_e store_size(input logic [1:0] w);
    case (w)
      SW_BYTE: return SZ_BYTE;
      SW_HALF: return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/load_store_unit_lane_align.sv
// ============================================================================
// Module : lsu_lane_align
// Brief  : Byte-enable generation, store replication, load extract/extend.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_lane_align
  import load_store_unit_pkg::*;
(
  input  access_size_e size_i,
  input  logic [1:0]   offset_i,
  input  logic [31:0]  store_data_i,
  input  logic [31:0]  load_word_i,
  input  logic [2:0]   load_funct3_i,
  input  logic [1:0]   load_offset_i,
  output logic [3:0]   byte_en_o,
  output logic [31:0]  store_data_o,
  output logic [31:0]  load_data_o
);

  logic [7:0]  w_lane_byte;
  logic [15:0] w_lane_half;
  logic        w_unsigned;

  always_comb begin
    byte_en_o    = 4'b1111;
    store_data_o = store_data_i;
    case (size_i)
      SZ_BYTE: begin
        byte_en_o    = 4'b0001 << offset_i;
        store_data_o = {4{store_data_i[7:0]}};
      end
      SZ_HALF: begin
        byte_en_o    = 4'b0011 << {offset_i[1], 1'b0};
        store_data_o = {2{store_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  assign w_lane_byte = load_word_i[{load_offset_i, 3'b000} +: 8];
  assign w_lane_half = load_offset_i[1] ? load_word_i[31:16] : load_word_i[15:0];
  assign w_unsigned  = load_funct3_i[2];

  always_comb begin
    load_data_o = load_word_i;
    case (load_size(load_funct3_i))
      SZ_BYTE: load_data_o = {{24{w_lane_byte[7] & ~w_unsigned}}, w_lane_byte};
      SZ_HALF: load_data_o = {{16{w_lane_half[15] & ~w_unsigned}}, w_lane_half};
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// ============================================================================
// Module : load_store_unit
// Brief  : Memory-stage load/store sequencer with bus timeout.
//          Define MISALIGN_TRAP_EN to trap misaligned accesses instead of
//          forcing them to natural alignment.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADDR_WIDTH     = 32
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [3:0]            DATA_MEM_READ,
  input  logic [2:0]            DATA_MEM_WRITE,
  input  logic [ADDR_WIDTH-1:0] ADDRESS,
  input  logic [31:0]           WRITE_DATA,
  output logic [31:0]           READ_DATA,
  output logic                  BUSY,
  output logic                  BUS_ERROR,
  output logic                  MEM_READ,
  output logic                  MEM_WRITE,
  output logic [ADDR_WIDTH-3:0] MEM_ADDRESS,
  output logic [31:0]           MEM_WRITEDATA,
  output logic [3:0]            MEM_BYTE_EN,
  input  logic [31:0]           MEM_READDATA,
  input  logic                  MEM_ACK
`ifdef MISALIGN_TRAP_EN
  ,
  output logic                  MISALIGNED
`endif
);

  localparam logic [7:0] c_TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  lsu_state_e            state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  rd_q, rd_d, wr_q, wr_d;
  logic [ADDR_WIDTH-3:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            be_q, be_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [1:0]            offset_q, offset_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic                  w_store_req, w_req, w_trap, w_busy;
  access_size_e          w_size;
  logic [1:0]            w_offset;
  logic [3:0]            w_be;
  logic [31:0]           w_store_data, w_load_data;

  // Store wins when both enables are set
  assign w_store_req = DATA_MEM_WRITE[2];
  assign w_req       = DATA_MEM_WRITE[2] | DATA_MEM_READ[3];
  assign w_size      = w_store_req ? store_size(DATA_MEM_WRITE[1:0])
                                   : load_size(DATA_MEM_READ[2:0]);

  always_comb begin
    w_offset = ADDRESS[1:0];
    case (w_size)
      SZ_HALF: w_offset = {ADDRESS[1], 1'b0};
      SZ_WORD: w_offset = 2'b00;
      default: ;
    endcase
  end

  lsu_lane_align u_lane_align (
    .size_i        (w_size),
    .offset_i      (w_offset),
    .store_data_i  (WRITE_DATA),
    .load_word_i   (MEM_READDATA),
    .load_funct3_i (funct3_q),
    .load_offset_i (offset_q),
    .byte_en_o     (w_be),
    .store_data_o  (w_store_data),
    .load_data_o   (w_load_data)
  );

`ifdef MISALIGN_TRAP_EN
  logic w_misaligned, mis_q, mis_d;

  assign w_misaligned = (w_size == SZ_HALF && ADDRESS[0]) ||
                        (w_size == SZ_WORD && ADDRESS[1:0] != 2'b00);
  assign w_trap       = w_misaligned;
  assign mis_d        = (state_q == ST_IDLE) && w_req && w_misaligned;
  assign MISALIGNED   = mis_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) mis_q <= 1'b0;
    else       mis_q <= mis_d;
  end
`else
  assign w_trap = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    funct3_d = funct3_q;
    offset_d = offset_q;
    rdata_d  = rdata_q;
    err_d    = 1'b0;
    w_busy   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        w_busy = w_req;
        if (w_req) begin
          if (w_trap) begin
            state_d = ST_DONE;
          end else begin
            state_d  = ST_WAIT;
            cnt_d    = 8'd0;
            rd_d     = ~w_store_req;
            wr_d     = w_store_req;
            addr_d   = ADDRESS[ADDR_WIDTH-1:2];
            wdata_d  = w_store_data;
            be_d     = w_be;
            funct3_d = DATA_MEM_READ[2:0];
            offset_d = w_offset;
          end
        end
      end
      ST_WAIT: begin
        w_busy = 1'b1;
        cnt_d  = cnt_q + 8'd1;
        if (MEM_ACK) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = ST_DONE;
          if (rd_q) rdata_d = w_load_data;
        end else if (cnt_q == c_TIMEOUT_LAST) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          err_d   = 1'b1;
          rdata_d = 32'd0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 8'd0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= 32'd0;
      be_q     <= 4'd0;
      funct3_q <= 3'd0;
      offset_q <= 2'd0;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      funct3_q <= funct3_d;
      offset_q <= offset_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign BUSY          = w_busy;
  assign READ_DATA     = rdata_q;
  assign BUS_ERROR     = err_q;
  assign MEM_READ      = rd_q;
  assign MEM_WRITE     = wr_q;
  assign MEM_ADDRESS   = addr_q;
  assign MEM_WRITEDATA = wdata_q;
  assign MEM_BYTE_EN   = be_q;

endmodule

`default_nettype wire
